// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and default parameters for the program loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;
  localparam int ADDR_W_DEF = 10;
  localparam int BASE_ADDR_DEF = 0;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream, instruction-memory write port and status of the loader.
interface imem_loader_if #(parameter int ADDR_W = imem_loader_pkg::ADDR_W_DEF);
  logic start;
  logic s_valid;
  logic [7:0] s_data;
  logic s_ready;
  logic im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0] im_wdata;
  logic cpu_hold;
  logic done;
  logic err;
  logic [ADDR_W:0] words_loaded;
  modport master (
    output start, s_valid, s_data,
    input s_ready, im_we, im_addr, im_wdata, cpu_hold, done, err, words_loaded
  );
  modport slave (
    input start, s_valid, s_data,
    output s_ready, im_we, im_addr, im_wdata, cpu_hold, done, err, words_loaded
  );
endinterface

// File: rtl/imem_word_packer.sv
// imem_word_packer: big-endian byte-to-word shift register with a one-cycle word_valid on the 4th byte.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [23:0] sr_q, sr_d;
  logic [1:0] cnt_q, cnt_d;
  assign word_o = {sr_q, byte_i};
  assign word_valid_o = byte_valid_i && cnt_q == 2'd3;
  always_comb begin
    sr_d = clr_i ? '0 : byte_valid_i ? {sr_q[15:0], byte_i} : sr_q;
    cnt_d = clr_i ? '0 : byte_valid_i ? cnt_q + 2'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and holds the CPU until the image is complete and verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BASE_ADDR = BASE_ADDR_DEF
) (
  input logic clk,
  input logic rst_n,
  imem_loader_if.slave bus
);
  localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_t state_q, state_d;
  logic [7:0] len_hi_q, len_hi_d, acc_q, acc_d;
  logic [15:0] len_q, len_d;
  logic [ADDR_W:0] wl_q, wl_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic accept, restart, word_valid;
  logic [31:0] word;
  logic [16:0] n;
  assign bus.s_ready = state_q inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign accept = bus.s_valid && bus.s_ready;
  assign restart = bus.start && state_q inside {IDLE, DONE, ERR};
  assign n = {1'b0, len_hi_q, bus.s_data};
  assign bus.im_we = we_q;
  assign bus.im_addr = addr_q;
  assign bus.im_wdata = wdata_q;
  assign bus.done = state_q == DONE;
  assign bus.err = state_q == ERR;
  assign bus.cpu_hold = state_q != DONE;
  assign bus.words_loaded = wl_q;
  imem_word_packer u_packer (
    .clk(clk),
    .rst_n(rst_n),
    .clr_i(restart),
    .byte_valid_i(accept && state_q == DATA),
    .byte_i(bus.s_data),
    .word_valid_o(word_valid),
    .word_o(word)
  );
  always_comb begin
    state_d = state_q;
    len_hi_d = len_hi_q;
    len_d = len_q;
    acc_d = accept ? acc_q ^ bus.s_data : acc_q;
    wl_d = wl_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: if (bus.start) begin
        state_d = LEN_HI;
        wl_d = '0;
        acc_d = '0;
      end
      LEN_HI: if (accept) begin
        len_hi_d = bus.s_data;
        state_d = LEN_LO;
      end
      // Oversize lengths are rejected here, so the address counter can never wrap.
      LEN_LO: if (accept) begin
        len_d = n[15:0];
        state_d = n > MAX_N ? ERR : n == 17'd0 ? CSUM : DATA;
      end
      DATA: if (word_valid) begin
        we_d = 1'b1;
        wdata_d = word;
        addr_d = BASE + wl_q[ADDR_W-1:0];
        wl_d = wl_q + (ADDR_W+1)'(1);
        if (17'(wl_q) + 17'd1 == {1'b0, len_q}) state_d = CSUM;
      end
      CSUM: if (accept) state_d = bus.s_data == acc_q ? DONE : ERR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      len_hi_q <= '0;
      len_q <= '0;
      acc_q <= '0;
      wl_q <= '0;
      we_q <= 1'b0;
      addr_q <= BASE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_hi_q <= len_hi_d;
      len_q <= len_d;
      acc_q <= acc_d;
      wl_q <= wl_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
endmodule
